// File: rtl/cp0_intr_unit.sv
// ----------------------------------------------------------------------------
// cp0_intr_unit
//
// Coprocessor-0 / interrupt unit beside the ID stage of the 5-stage MIPS
// pipeline. Serves MFC0/MTC0 on the ID-stage CP0 port, synchronises and
// latches the external interrupt request, saves the return address in EPC,
// and redirects fetch (handler entry on a take, EPC on ERET) through a
// registered one-cycle jump request.
//
// Ports:
//   clk        main clock
//   rst        synchronous active-high reset
//   oper[1:0]  CP0 op of the ID instruction: 0 none, 1 MFC0, 2 MTC0, 3 ERET
//   en         ID instruction valid and advancing (gates oper and takes)
//   addr_r     CP0 register address (read and MTC0 write)
//   data_r     CP0 read data, combinational from addr_r
//   data_w     MTC0 write data
//   ret_addr   resume address saved into EPC when an interrupt is taken
//   ir_in      external interrupt request, asynchronous level
//   jump_en    registered one-cycle redirect pulse
//   jump_addr  redirect target, holds its last value while jump_en=0
//   in_isr     1 while in the ISR state
//   ir_pending interrupt latched and not yet taken
//
// Register map: 12 STATUS (bit0 IE), 13 CAUSE (bit0 pending, read-only),
// 14 EPC, 15 EHBR (handler entry). Everything else reads 0, writes ignored.
// ----------------------------------------------------------------------------
module cp0_intr_unit #(
    parameter logic [31:0] HANDLER_RESET = 32'h0000_0020,
    parameter int          IR_SYNC       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  oper,
    input  logic        en,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [31:0] data_w,
    input  logic [31:0] ret_addr,
    input  logic        ir_in,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        in_isr,
    output logic        ir_pending
);

    // A single flop is not a synchronizer; clamp to at least two stages.
    localparam int SYNC_N = (IR_SYNC < 2) ? 2 : IR_SYNC;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;
    localparam logic [4:0] ADDR_EHBR   = 5'd15;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_MFC0 = 2'd1,
        OP_MTC0 = 2'd2,
        OP_ERET = 2'd3
    } cp0_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [SYNC_N-1:0] sync_reg;
    logic        sync_prev_reg;
    logic        pending_reg;
    logic        ie_reg;
    logic [31:0] epc_reg;
    logic [31:0] ehbr_reg;
    logic        jump_en_reg;
    logic [31:0] jump_addr_reg;

    cp0_op_t     op;
    logic        ir_rise;
    logic        take;
    logic        eret_fire;
    logic        mtc0_fire;

    assign op = cp0_op_t'(oper);

    // ------------------------------------------------------------------
    // Interrupt request synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg      <= '0;
            sync_prev_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_N-2:0], ir_in};
            sync_prev_reg <= sync_reg[SYNC_N-1];
        end
    end

    assign ir_rise = sync_reg[SYNC_N-1] & ~sync_prev_reg;

    // ------------------------------------------------------------------
    // Control decode and next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        eret_fire  = en && (op == OP_ERET);
        mtc0_fire  = en && (op == OP_MTC0);

        // Any CP0 instruction in ID blocks the take; it is retried on the
        // next qualifying cycle because pending stays set.
        if (state_reg == ST_IDLE && ie_reg && pending_reg && en && op == OP_NONE) begin
            take = 1'b1;
        end

        if (take) begin
            state_next = ST_ISR;
        end else if (eret_fire) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Pending flag: a new edge in the take cycle wins over the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
        end else begin
            pending_reg <= ir_rise | (pending_reg & ~take);
        end
    end

    // ------------------------------------------------------------------
    // CP0 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_reg   <= 1'b0;
            epc_reg  <= 32'h0;
            ehbr_reg <= HANDLER_RESET;
        end else begin
            // take requires oper=none, so it never coincides with an MTC0.
            if (take) begin
                epc_reg <= ret_addr;
            end else if (mtc0_fire && addr_r == ADDR_EPC) begin
                epc_reg <= data_w;
            end
            if (mtc0_fire && addr_r == ADDR_STATUS) begin
                ie_reg <= data_w[0];
            end
            if (mtc0_fire && addr_r == ADDR_EHBR) begin
                ehbr_reg <= data_w;
            end
        end
    end

    // ------------------------------------------------------------------
    // Redirect request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_en_reg   <= 1'b0;
            jump_addr_reg <= 32'h0;
        end else begin
            jump_en_reg <= take | eret_fire;
            if (take) begin
                jump_addr_reg <= ehbr_reg;
            end else if (eret_fire) begin
                jump_addr_reg <= epc_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        data_r = 32'h0;
        case (addr_r)
            ADDR_STATUS: data_r = {31'h0, ie_reg};
            ADDR_CAUSE:  data_r = {31'h0, pending_reg};
            ADDR_EPC:    data_r = epc_reg;
            ADDR_EHBR:   data_r = ehbr_reg;
            default:     data_r = 32'h0;
        endcase
    end

    assign jump_en    = jump_en_reg;
    assign jump_addr  = jump_addr_reg;
    assign in_isr     = (state_reg == ST_ISR);
    assign ir_pending = pending_reg;

endmodule

// File: doc/cp0_intr_unit.md
Name: cp0_intr_unit

Overview:
- Coprocessor-0 / interrupt unit sitting beside the ID stage of the 5-stage MIPS pipeline.
- Serves MFC0/MTC0 register access on the ID-stage CP0 port.
- Latches the external interrupt request and saves the return address into EPC.
- Redirects fetch to the handler on an interrupt, and back to EPC on ERET, by driving the pipeline's registered jump request.

Parameters:
- HANDLER_RESET, 32'h0000_0020, reset value of EHBR (handler entry address).
- IR_SYNC, 2, number of synchronizer flops on ir_in (minimum 2).

Ports:
- clk  in  1  main clock
- rst  in  1  synchronous active-high reset
- oper  in  2  CP0 operation of the instruction in ID: 0 none, 1 MFC0, 2 MTC0, 3 ERET
- en  in  1  ID instruction is valid and advancing; oper and interrupt acceptance take effect only when en=1
- addr_r  in  5  CP0 read address (rd field of the ID instruction)
- data_r  out  32  CP0 read data, combinational from addr_r
- data_w  in  32  MTC0 write data (forwarded rt value)
- ret_addr  in  32  address to resume at if an interrupt is taken this cycle
- ir_in  in  1  external interrupt request, asynchronous level
- jump_en  out  1  registered one-cycle redirect pulse
- jump_addr  out  32  redirect target, valid while jump_en=1
- in_isr  out  1  1 while state=ISR
- ir_pending  out  1  interrupt latched and not yet taken

Behaviour:
Clock and reset:
- Single clock.
- Reset is synchronous and active-high, sampled on the rising edge of clk.

Register map:
- MTC0 uses addr_r as the write address.
- 12 STATUS: bit0 = IE, other bits read 0. Reset 0.
- 13 CAUSE: bit0 = pending, read-only; other bits read 0.
- 14 EPC: 32-bit, reset 0.
- 15 EHBR: 32-bit, reset HANDLER_RESET.
- All other addresses read 0; writes to them and to CAUSE are ignored.

Synchronizer and pending:
- ir_in passes through IR_SYNC flops, reset to 0.
- A rising edge at the synchronizer output sets pending.
- pending clears only in the cycle an interrupt is taken.
- If a new edge arrives in the take cycle, pending stays set.

State machine (2 states), reset state IDLE:
- IDLE, take condition: IE=1 & pending=1 & en=1 & oper=none.
- IDLE, take action:
  - EPC<=ret_addr
  - jump_addr<=EHBR
  - jump_en<=1 on the next edge
  - pending<=0
  - state<=ISR
- A CP0 instruction in ID blocks the take that cycle; the take is retried on the next qualifying cycle.
- ISR: no interrupt is taken (no nesting); edges still set pending.
- ERET with en=1, in either state: jump_addr<=EPC, jump_en<=1, state<=IDLE. IE is unchanged.
- MTC0 with en=1: the addressed register is written at the clock edge. It is legal in both states.
  - An EPC write in ISR affects a subsequent ERET.
  - An IE write takes effect for take decisions in the following cycle.
- MFC0 has no state effect.
- With en=0, oper is ignored entirely.

jump_en:
- High exactly one cycle after the take/ERET edge, otherwise 0.
- The datapath registers it once more before overriding the fetch address.
- jump_addr holds its last value when jump_en=0.

Reset values and reset behaviour:
- Reset values: jump_en 0, jump_addr 0, in_isr 0, ir_pending 0, data_r reflects reset registers.
- rst asserted mid-ISR or during a jump_en pulse: all state returns to reset values on that edge; no pulse follows.

Test Plan:
- Reset, then read regs 12..15 via MFC0 -> data_r = 0, 0, 0, 32'h20; reads of 0 and 31 -> 0; jump_en stays 0.
- MTC0 STATUS=1, pulse ir_in, ret_addr=32'h100, en=1, oper=0 -> after 2 sync cycles pending=1; next cycle take; jump_en=1 with jump_addr=32'h20 for exactly one cycle; EPC=32'h100; in_isr=1.
- In ISR: raise ir_in again -> ir_pending=1, no jump_en; then ERET with en=1 -> jump_en pulse with jump_addr=32'h100, in_isr=0; the pending interrupt is taken on the next qualifying cycle.
- Pending with IE=1 but en=0 or oper=MFC0 for 3 cycles -> no take; take occurs in the first cycle with en=1 & oper=0.
- MTC0 EHBR=32'h400 and EPC=32'h2000 in ISR, then ERET -> jump_addr=32'h2000; the next interrupt vectors to 32'h400.
- Assert rst in the cycle after a take (jump_en high) -> all outputs reset next edge, in_isr=0, EHBR=32'h20, no further pulse.
